instruction_fetch_queue: RTL and testbench

Instruction fetch front end sitting directly upstream of the instruction decode/control stage. It owns the fetch PC and issues word requests to a variable-latency instruction memory over a req/gnt/rvalid handshake. Each returned word is buffered, with its PC, in a small FIFO that drains to decode under valid/ready. A redirect input (taken branch or jump target) flushes the queue and discards stale in-flight responses.

---
 rtl/ifq_pkg.sv | 19 +
 rtl/instruction_fetch_queue_if.sv | 28 ++
 rtl/ifq_fifo.sv | 61 ++++++
 rtl/instruction_fetch_queue.sv | 105 ++++++++++
 tb/tb_instruction_fetch_queue.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/ifq_pkg.sv
// Shared types and constants for the instruction fetch queue: FSM states,
// instruction width, PC increment and the FIFO entry layout.
package ifq_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_STEP = 4;

  typedef enum logic [1:0] {
    S_RESET,
    S_FETCH,
    S_DRAIN
  } ifq_state_t;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } ifq_entry_t;

endpackage

// File: rtl/instruction_fetch_queue_if.sv
// Bundles the instruction-memory request/response bus, the redirect input and
// the decode-side valid/ready port. master = fetch queue, slave = its environment.
interface instruction_fetch_queue_if;
  import ifq_pkg::*;

  logic               imem_req;
  logic [31:0]        imem_addr;
  logic               imem_gnt;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;
  logic               redirect;
  logic [31:0]        redirect_pc;
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr;
  logic [31:0]        instr_pc;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, instr_ready
  );

endinterface

// File: rtl/ifq_fifo.sv
// Small {pc, instr} FIFO with flush. Storage is reset so the head reads zero
// after reset; head is read straight from storage (no extra output stage).
module ifq_fifo
  import ifq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     push,
  input  ifq_entry_t               push_data,
  input  logic                     pop,
  output ifq_entry_t               head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W:0]   count_reg;
  ifq_entry_t       entries [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      ifq_entry_t entry_reg;

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          entry_reg <= '0;
        end else if (push && !flush && (wr_ptr_reg == PTR_W'(gi))) begin
          entry_reg <= push_data;
        end
      end

      assign entries[gi] = entry_reg;
    end
  endgenerate

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg <= count_reg + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
  end

  assign head  = entries[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/instruction_fetch_queue.sv
// Fetch front end: owns the fetch PC, issues credit-limited imem requests and
// buffers responses for decode. Optional same-cycle bypass under IFQ_BYPASS_EN.
module instruction_fetch_queue
  import ifq_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clock,
  input  logic                       reset_n,
  instruction_fetch_queue_if.master  bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  ifq_state_t       state_reg, state_next;
  logic [31:0]      fetch_pc_reg, fetch_pc_next;
  logic [31:0]      rsp_pc_reg, rsp_pc_next;
  logic [CNT_W-1:0] outstanding_reg, outstanding_next;
  logic [CNT_W-1:0] discard_reg, discard_next;
  logic [CNT_W-1:0] count;
  logic [31:0]      redirect_target;
  logic             grant, rsp_valid, keep, bypass, push, pop;
  ifq_entry_t       head;

  assign redirect_target = bus.redirect_pc & ~32'd3;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp_valid = bus.imem_rvalid && (outstanding_reg != '0);
  assign keep      = rsp_valid && (discard_reg == '0) && !bus.redirect;

  assign bus.imem_req  = (state_reg == S_FETCH) && !bus.redirect &&
                         (({1'b0, count} + {1'b0, outstanding_reg}) < (CNT_W+1)'(DEPTH));
  assign bus.imem_addr = fetch_pc_reg;
  assign grant         = bus.imem_req && bus.imem_gnt;

`ifdef IFQ_BYPASS_EN
  assign bypass = keep && (count == '0);
`else
  assign bypass = 1'b0;
`endif

  assign bus.instr_valid = ((count != '0) || bypass) && !bus.redirect;
  assign bus.instr       = bypass ? bus.imem_rdata : head.instr;
  assign bus.instr_pc    = bypass ? rsp_pc_reg     : head.pc;

  assign pop  = bus.instr_valid && bus.instr_ready && (count != '0);
  assign push = keep && !(bypass && bus.instr_ready);

  ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .flush     (bus.redirect),
    .push      (push),
    .push_data ('{pc: rsp_pc_reg, instr: bus.imem_rdata}),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= S_RESET;
      fetch_pc_reg    <= RESET_PC;
      rsp_pc_reg      <= RESET_PC;
      outstanding_reg <= '0;
      discard_reg     <= '0;
    end else begin
      state_reg       <= state_next;
      fetch_pc_reg    <= fetch_pc_next;
      rsp_pc_reg      <= rsp_pc_next;
      outstanding_reg <= outstanding_next;
      discard_reg     <= discard_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    fetch_pc_next    = fetch_pc_reg;
    rsp_pc_next      = rsp_pc_reg;
    outstanding_next = outstanding_reg + CNT_W'(grant) - CNT_W'(rsp_valid);
    discard_next     = discard_reg;

    if (bus.redirect) begin
      // Everything still in flight is stale; the word returning now is dropped too.
      fetch_pc_next = redirect_target;
      rsp_pc_next   = redirect_target;
      discard_next  = outstanding_reg - CNT_W'(rsp_valid);
    end else begin
      if (grant)
        fetch_pc_next = fetch_pc_reg + 32'(PC_STEP);
      if (keep)
        rsp_pc_next = rsp_pc_reg + 32'(PC_STEP);
      if (rsp_valid && (discard_reg != '0))
        discard_next = discard_reg - CNT_W'(1);
    end

    case (state_reg)
      S_RESET:          state_next = S_FETCH;
      S_FETCH, S_DRAIN: state_next = (discard_next != '0) ? S_DRAIN : S_FETCH;
      default:          state_next = S_RESET;
    endcase
  end

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Randomized bench for instruction_fetch_queue: a queue-based model of the
// in-flight requests and the decode queue predicts every output each cycle.
module tb_instruction_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          NCYC     = 3000;

`ifdef IFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          rdy;
    bit          stale;
  } flight_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  instruction_fetch_queue_if bus ();

  instruction_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  flight_t     fl_q[$];
  entry_t      fifo_q[$];
  flight_t     fe;
  entry_t      ee;
  int          cyc;
  int          vectors    = 0;
  int          miscompares = 0;
  int          stale_n, mode, lat;
  bit          spurious, exp_req, exp_valid, keep_now, byp;
  logic [31:0] m_fetch_pc, exp_instr, exp_pc;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    bus.imem_gnt = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata = '0;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    bus.instr_ready = 1'b0;
    m_fetch_pc = RESET_PC;
    cyc = -1;

    repeat (3) @(posedge clock);
    #1;
    check_val("rst_req",      32'(bus.imem_req),    32'd0);
    check_val("rst_addr",     bus.imem_addr,        RESET_PC);
    check_val("rst_valid",    32'(bus.instr_valid), 32'd0);
    check_val("rst_instr",    bus.instr,            32'd0);
    check_val("rst_instr_pc", bus.instr_pc,         32'd0);

    @(negedge clock);
    reset_n = 1'b1;

    for (cyc = 0; cyc < NCYC; cyc++) begin
      // Phases: streaming, stalled decode, streaming, fixed redirect, random.
      if (cyc < 10 || (cyc >= 25 && cyc <= 35)) mode = 0;
      else if (cyc < 25)                        mode = 1;
      else                                      mode = 2;

      bus.instr_ready = (mode == 1) ? 1'b0 : (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      bus.imem_gnt    = (mode != 2) ? 1'b1 : ($urandom_range(0, 2) != 0);
      bus.redirect    = (cyc == 35) || (mode == 2 && $urandom_range(0, 24) == 0);
      bus.redirect_pc = (cyc == 35) ? 32'h0000_0203 : $urandom;
      spurious        = 1'b0;
      bus.imem_rvalid = (fl_q.size() > 0) && (fl_q[0].rdy <= cyc);
      bus.imem_rdata  = bus.imem_rvalid ? fl_q[0].data : $urandom;
      if (!bus.imem_rvalid && fl_q.size() == 0 && mode == 2 && $urandom_range(0, 9) == 0) begin
        bus.imem_rvalid = 1'b1;
        spurious = 1'b1;
      end
      #1;

      stale_n = 0;
      foreach (fl_q[i]) if (fl_q[i].stale) stale_n++;
      exp_req   = (cyc > 0) && (stale_n == 0) && (fifo_q.size() + fl_q.size() < DEPTH) && !bus.redirect;
      keep_now  = bus.imem_rvalid && !spurious && (fl_q.size() > 0) && !fl_q[0].stale && !bus.redirect;
      byp       = BYP && keep_now && (fifo_q.size() == 0);
      exp_valid = !bus.redirect && ((fifo_q.size() > 0) || byp);

      check_val("imem_req",    32'(bus.imem_req),    32'(exp_req));
      check_val("imem_addr",   bus.imem_addr,        m_fetch_pc);
      check_val("instr_valid", 32'(bus.instr_valid), 32'(exp_valid));
      if (exp_valid) begin
        if (fifo_q.size() > 0) begin
          exp_instr = fifo_q[0].instr;
          exp_pc    = fifo_q[0].pc;
        end else begin
          exp_instr = fl_q[0].data;
          exp_pc    = fl_q[0].addr;
        end
        check_val("instr",    bus.instr,    exp_instr);
        check_val("instr_pc", bus.instr_pc, exp_pc);
        if (bus.instr_ready)
          $display("cyc=%0d deliver pc=%h instr=%h", cyc, exp_pc, exp_instr);
      end

      if (bus.redirect) begin
        if (bus.imem_rvalid && !spurious) void'(fl_q.pop_front());
        foreach (fl_q[i]) fl_q[i].stale = 1'b1;
        fifo_q.delete();
        m_fetch_pc = bus.redirect_pc & ~32'd3;
      end else begin
        if (exp_valid && bus.instr_ready && fifo_q.size() > 0) void'(fifo_q.pop_front());
        if (bus.imem_rvalid && !spurious) begin
          fe = fl_q.pop_front();
          if (!fe.stale && !(byp && bus.instr_ready)) begin
            ee.pc    = fe.addr;
            ee.instr = fe.data;
            fifo_q.push_back(ee);
          end
        end
        if (exp_req && bus.imem_gnt) begin
          lat      = (mode == 2) ? int'($urandom_range(0, 4)) : 0;
          fe.addr  = m_fetch_pc;
          fe.data  = $urandom;
          fe.rdy   = cyc + 1 + lat;
          fe.stale = 1'b0;
          fl_q.push_back(fe);
          m_fetch_pc = m_fetch_pc + 32'd4;
        end
      end

      @(posedge clock);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
